// File: rtl/if_stage_pkg.sv
// if_stage_pkg: constants and types shared by the instruction-fetch stage.
//   RESET_PC  - first fetch address after reset
//   NOP_INST  - instruction word presented to decode during a bubble
//   fetch_state_e - fetch FSM state encodings
//   seq_pc()  - sequential successor of a fetch address (32-bit wrap)
package if_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    S_REQ  = 2'b00,  // request driven, waiting for grant
    S_WAIT = 2'b01,  // one request outstanding, waiting for the word
    S_FULL = 2'b10   // word parked in the skid buffer, no request
  } fetch_state_e;

  // Wraps naturally at 32 bits: 32'hFFFF_FFFC -> 32'h0000_0000.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// if_skid_buf: one-entry buffer holding a fetched word and its PC while
// decode is stalled.
//   clk, rst        - clock, synchronous active-high reset
//   push_i          - capture pc_i/inst_i (entry becomes valid)
//   pop_i           - entry consumed (entry becomes empty)
//   pc_i, inst_i    - word and its fetch PC
//   valid_o, pc_o, inst_o - buffered entry
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  // Buffer entry register; push has priority (push and pop never coincide).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0000_0000;
      inst_q  <= NOP_INST;
    end else if (push_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a single outstanding memory request,
// one-entry skid buffer and branch-delay-slot redirect handling.
//   clk, rst                     - clock, synchronous active-high reset
//   stall                        - decode cannot accept; IF/ID outputs hold
//   branch_flag_i, target_address_i - taken branch/jump resolved in decode
//   imem_req, imem_addr          - fetch request and word address
//   imem_gnt                     - request accepted this cycle
//   imem_rvalid, imem_rdata      - returned instruction word
//   id_pc, id_inst, id_valid     - IF/ID register presented to decode
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_flag_i,
  input  logic [31:0] target_address_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;   // address of the next request
  logic [31:0]  out_pc_q, out_pc_d;       // address of the outstanding request
  logic         redir_q, redir_d;         // redirect waiting for delay-slot grant
  logic [31:0]  tgt_q, tgt_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  id_inst_q, id_inst_d;
  logic         id_valid_q, id_valid_d;

  logic         take_branch_s;
  logic         eff_redir_s;
  logic [31:0]  eff_tgt_s;
  logic         skid_push_s;
  logic         skid_pop_s;
  logic         skid_valid_s;
  logic [31:0]  skid_pc_s;
  logic [31:0]  skid_inst_s;

  // A branch only counts when decode really consumes the instruction.
  assign take_branch_s = branch_flag_i & id_valid_q & ~stall;
  assign eff_redir_s   = redir_q | take_branch_s;
  assign eff_tgt_s     = take_branch_s ? target_address_i : tgt_q;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (skid_push_s),
    .pop_i   (skid_pop_s),
    .pc_i    (out_pc_q),
    .inst_i  (imem_rdata),
    .valid_o (skid_valid_s),
    .pc_o    (skid_pc_s),
    .inst_o  (skid_inst_s)
  );

  // Next-state, PC and IF/ID logic.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    out_pc_d    = out_pc_q;
    redir_d     = redir_q;
    tgt_d       = tgt_q;
    id_pc_d     = id_pc_q;
    id_inst_d   = id_inst_q;
    id_valid_d  = id_valid_q;
    skid_push_s = 1'b0;
    skid_pop_s  = 1'b0;

    // Default when decode advances: bubble (overridden if a word is ready).
    if (!stall) begin
      id_valid_d = 1'b0;
      id_inst_d  = NOP_INST;
    end else begin
      id_valid_d = id_valid_q;
    end

    case (state_q)
      S_REQ: begin
        // In REQ the pending fetch address is always the delay slot of a
        // branch sitting in decode, so the redirect waits for its grant.
        if (imem_gnt) begin
          state_d    = S_WAIT;
          out_pc_d   = fetch_pc_q;
          fetch_pc_d = eff_redir_s ? eff_tgt_s : seq_pc(fetch_pc_q);
          redir_d    = 1'b0;
        end else begin
          redir_d = eff_redir_s;
          tgt_d   = eff_tgt_s;
        end
      end
      S_WAIT: begin
        // Delay slot already granted: the target is the very next fetch.
        if (take_branch_s) begin
          fetch_pc_d = target_address_i;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (imem_rvalid) begin
          if (!stall) begin
            id_pc_d    = out_pc_q;
            id_inst_d  = imem_rdata;
            id_valid_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            skid_push_s = 1'b1;
            state_d     = S_FULL;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FULL: begin
        if (take_branch_s) begin
          fetch_pc_d = target_address_i;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (!stall) begin
          id_pc_d    = skid_pc_s;
          id_inst_d  = skid_inst_s;
          id_valid_d = skid_valid_s;
          skid_pop_s = 1'b1;
          state_d    = S_REQ;
        end else begin
          state_d = S_FULL;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State, PC and IF/ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      out_pc_q   <= 32'h0000_0000;
      redir_q    <= 1'b0;
      tgt_q      <= 32'h0000_0000;
      id_pc_q    <= 32'h0000_0000;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_pc_q   <= out_pc_d;
      redir_q    <= redir_d;
      tgt_q      <= tgt_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = fetch_pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_flag_i;
  logic [31:0] target_address_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  if_stage dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .branch_flag_i    (branch_flag_i),
    .target_address_i (target_address_i),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_gnt         (imem_gnt),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .id_pc            (id_pc),
    .id_inst          (id_inst),
    .id_valid         (id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: memory has at most one word in flight, a word that
  // arrives while decode stalls waits in a one-deep holding slot, and the
  // fetch address stream follows program order with a single delay slot.
  bit          m_out;       // a granted request has not yet returned
  logic [31:0] m_out_pc;
  bit          m_buf_v;     // returned word waiting for decode
  logic [31:0] m_buf_pc, m_buf_inst;
  bit          m_id_v;
  logic [31:0] m_id_pc, m_id_inst;
  logic [31:0] m_next;      // next address that must be requested
  logic [31:0] m_last_gnt;  // most recently granted address
  bit          m_pend;
  logic [31:0] m_pend_ds, m_pend_tgt;
  logic [31:0] m_ds_guard;  // delay slot of the last branch (not a branch itself)

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out = 1'b0; m_out_pc = 32'h0; m_buf_v = 1'b0; m_buf_pc = 32'h0; m_buf_inst = 32'h0;
    m_id_v = 1'b0; m_id_pc = 32'h0; m_id_inst = 32'h0;
    m_next = 32'hBFC0_0000; m_last_gnt = 32'h1; m_pend = 1'b0;
    m_pend_ds = 32'h1; m_pend_tgt = 32'h0; m_ds_guard = 32'h1;
  endtask

  task automatic model_edge();
    bit          arrive, grant, taken;
    logic [31:0] old_pc, ds;
    if (rst) begin
      model_reset();
      return;
    end
    arrive = imem_rvalid && m_out;
    grant  = !m_out && !m_buf_v && imem_gnt;
    taken  = branch_flag_i && m_id_v && !stall;
    old_pc = m_id_pc;
    if (!stall) begin
      if (m_buf_v) begin
        m_id_v = 1'b1; m_id_pc = m_buf_pc; m_id_inst = m_buf_inst; m_buf_v = 1'b0;
      end else if (arrive) begin
        m_id_v = 1'b1; m_id_pc = m_out_pc; m_id_inst = imem_rdata;
      end else begin
        m_id_v = 1'b0; m_id_inst = 32'h0;
      end
    end else if (arrive) begin
      m_buf_v = 1'b1; m_buf_pc = m_out_pc; m_buf_inst = imem_rdata;
    end
    if (arrive) m_out = 1'b0;
    if (grant) begin
      m_out = 1'b1; m_out_pc = m_next; m_last_gnt = m_next;
      if (m_pend && m_next == m_pend_ds) begin
        m_next = m_pend_tgt; m_pend = 1'b0;
      end else begin
        m_next = m_next + 32'd4;
      end
    end
    if (taken) begin
      ds = old_pc + 32'd4;
      m_ds_guard = ds;
      if (m_last_gnt == ds) begin
        m_next = target_address_i;
      end else begin
        m_pend = 1'b1; m_pend_ds = ds; m_pend_tgt = target_address_i;
      end
    end
  endtask

  // Compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", {31'h0, imem_req}, {31'h0, (!m_out && !m_buf_v)});
      if (!m_out && !m_buf_v) chk("imem_addr", imem_addr, m_next);
      chk("id_valid", {31'h0, id_valid}, {31'h0, m_id_v});
      if (m_id_v) chk("id_pc", id_pc, m_id_pc);
      chk("id_inst", id_inst, m_id_inst);
    end
  end

  // One clock: drive inputs, advance the model at the edge, return at negedge.
  // rv: 0 no response, 1 respond if a request is outstanding, 2 force rvalid.
  task automatic cyc(input logic s, input logic g, input int rv, input logic b,
                     input logic [31:0] t);
    bit allowed, sampled;
    stall       = s;
    imem_gnt    = g;
    imem_rdata  = $urandom;
    imem_rvalid = (rv == 2) || (rv == 1 && m_out);
    allowed = m_id_v && !m_pend && (m_id_pc != m_ds_guard) &&
              ((m_id_pc + 32'd4 == m_last_gnt) || (m_id_pc + 32'd4 == m_next));
    sampled = m_id_v && !s;
    branch_flag_i    = b && (allowed || !sampled);
    target_address_i = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 0, 1'b0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic run_to_id(input logic [31:0] pc, input string nm);
    int k = 0;
    while (!(id_valid === 1'b1 && id_pc == pc) && k < 64) begin
      cyc(1'b0, 1'b1, 1, 1'b0, 32'h0);
      k++;
    end
    if (k >= 64) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: id_pc %h never presented", nm, pc);
    end
  endtask

  initial begin
    logic [31:0] tr, t;
    rst = 1'b1; stall = 1'b0; branch_flag_i = 1'b0; target_address_i = 32'h0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    model_reset();
    @(negedge clk);
    cyc(1'b0, 1'b0, 0, 1'b0, 32'h0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b1, 2, 1'b0, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    rst = 1'b0;

    // Sequential fetch: grant then response, one cycle each.
    chk("seq_addr0", imem_addr, 32'hBFC0_0000);
    cyc(1'b0, 1'b1, 0, 1'b0, 32'h0);
    chk("seq_req_wait", {31'h0, imem_req}, 32'h0);
    cyc(1'b0, 1'b0, 1, 1'b0, 32'h0);
    chk("seq_id_valid", {31'h0, id_valid}, 32'h1);
    chk("seq_id_pc0", id_pc, 32'hBFC0_0000);
    chk("seq_addr1", imem_addr, 32'hBFC0_0004);
    cyc(1'b0, 1'b1, 0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1, 1'b0, 32'h0);
    chk("seq_id_pc1", id_pc, 32'hBFC0_0004);
    chk("seq_addr2", imem_addr, 32'hBFC0_0008);

    // Stall while the response for BFC0_0008 arrives.
    cyc(1'b0, 1'b1, 0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1, 1'b0, 32'h0);
    chk("stall_req", {31'h0, imem_req}, 32'h0);
    chk("stall_id_pc", id_pc, 32'hBFC0_0004);
    cyc(1'b1, 1'b1, 0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 2, 1'b0, 32'h0);
    chk("stall_req3", {31'h0, imem_req}, 32'h0);
    chk("stall_id_pc3", id_pc, 32'hBFC0_0004);
    cyc(1'b0, 1'b0, 0, 1'b0, 32'h0);
    chk("unstall_id_pc", id_pc, 32'hBFC0_0008);
    chk("unstall_addr", imem_addr, 32'hBFC0_000C);

    // Jump at BFC0_0010 to BFC0_0100, delay slot granted with the branch.
    run_to_id(32'hBFC0_0010, "reach_j");
    cyc(1'b0, 1'b1, 1, 1'b1, 32'hBFC0_0100);
    cyc(1'b0, 1'b1, 1, 1'b0, 32'h0);
    chk("ds_id_pc", id_pc, 32'hBFC0_0014);
    chk("tgt_addr", imem_addr, 32'hBFC0_0100);
    cyc(1'b0, 1'b1, 1, 1'b0, 32'h0);
    cyc(1'b0, 1'b1, 1, 1'b0, 32'h0);
    chk("tgt_id_pc", id_pc, 32'hBFC0_0100);

    // Jump while the delay-slot request is held ungranted for 4 cycles.
    do_reset();
    run_to_id(32'hBFC0_0010, "reach_j2");
    cyc(1'b0, 1'b0, 1, 1'b1, 32'hBFC0_0100);
    for (int i = 0; i < 3; i++) begin
      chk("hold_addr", imem_addr, 32'hBFC0_0014);
      cyc(1'b0, 1'b0, 1, 1'b0, 32'h0);
    end
    chk("hold_addr4", imem_addr, 32'hBFC0_0014);
    cyc(1'b0, 1'b1, 1, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 1, 1'b0, 32'h0);
    chk("hold_ds_pc", id_pc, 32'hBFC0_0014);
    chk("hold_tgt_addr", imem_addr, 32'hBFC0_0100);

    // PC wrap-around.
    do_reset();
    run_to_id(32'hBFC0_0010, "reach_j3");
    cyc(1'b0, 1'b1, 1, 1'b1, 32'hFFFF_FFF8);
    run_to_id(32'hFFFF_FFFC, "reach_wrap");
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Reset in WAIT, then a stale response after release.
    do_reset();
    cyc(1'b0, 1'b1, 0, 1'b0, 32'h0);
    do_reset();
    cyc(1'b0, 1'b0, 2, 1'b0, 32'h0);
    chk("stale_id_valid", {31'h0, id_valid}, 32'h0);
    chk("stale_addr", imem_addr, 32'hBFC0_0000);
    chk("stale_req", {31'h0, imem_req}, 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        tr = $urandom;
        t  = {tr[31:2], 2'b00};
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFF8;
        cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6,
            ($urandom_range(0, 19) == 0) ? 2 : int'($urandom_range(0, 1)),
            $urandom_range(0, 4) == 0, t);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  in  1  pipeline clock, all state on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 stall  in  1  decode cannot accept; hold IF/ID outputs.
REQ-005 branch_flag_i  in  1  decode resolved a taken branch/jump this cycle.
REQ-006 target_address_i  in  32  branch/jump target from decode.
REQ-007 imem_req  out  1  fetch request valid.
REQ-008 imem_addr  out  32  fetch word address, stable while imem_req=1 and imem_gnt=0.
REQ-009 imem_gnt  in  1  request accepted this cycle.
REQ-010 imem_rvalid  in  1  instruction word returned this cycle.
REQ-011 imem_rdata  in  32  returned instruction.
REQ-012 id_pc  out  32  PC of instruction presented to decode.
REQ-013 id_inst  out  32  instruction presented to decode; 32'h0 (nop) when id_valid=0.
REQ-014 id_valid  out  1  id_pc/id_inst hold a real instruction.

Function
REQ-015 FSM states: REQ (imem_req=1, waiting imem_gnt), WAIT (one request outstanding, waiting imem_rvalid), FULL (skid buffer occupied, no request).
REQ-016 At most one outstanding request; imem_req SHALL be 0 in WAIT and FULL.
REQ-017 REQ->WAIT on imem_gnt; fetch PC advances to next PC in the same edge.
REQ-018 Next PC = pending target if redirect pending, else fetch PC + 4; the pending flag clears when that target is granted.
REQ-019 WAIT, imem_rvalid, stall=0: word loads IF/ID register (id_valid=1) at next edge, state -> REQ.
REQ-020 WAIT, imem_rvalid, stall=1: word stored in 1-entry skid buffer with its PC, state -> FULL.
REQ-021 FULL, stall=0: buffer moves to IF/ID register, buffer empties, state -> REQ.
REQ-022 stall=1: id_pc, id_inst, id_valid SHALL not change.
REQ-023 stall=0 and no word available: id_valid=0, id_inst=0 next cycle (bubble).
REQ-024 Branch delay slot: redirect SHALL NOT kill the instruction sequentially after the branch; it is delivered, then target.
REQ-025 branch_flag_i sampled only when id_valid=1 and stall=0; sets redirect pending with target_address_i.
REQ-026 If the delay-slot address is already granted or buffered, target is the next fetch; if still in REQ ungranted, imem_addr stays until granted, then target follows.
REQ-027 Target address SHALL be word-aligned by caller; bits [1:0] passed through unchanged.
REQ-028 PC arithmetic 32-bit wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-029 imem_rvalid in REQ or FULL (nothing outstanding) SHALL be ignored.
REQ-030 Simultaneous branch_flag_i and imem_rvalid: both take effect same edge.

Reset
REQ-031 While rst=1 at an edge: state REQ, fetch PC=RESET_PC, redirect pending=0, buffer empty, id_valid=0, id_pc=0, id_inst=0.
REQ-032 imem_req=1 with imem_addr=RESET_PC in the first cycle after rst deasserts; reset mid-fetch discards the outstanding response per REQ-029.

Structure
REQ-033 Shared include: RESET_PC default, NOP_INST 32'h0, FSM state encodings.
REQ-034 One sub-module if_skid_buf (1-entry pc+inst buffer, valid flag); FSM and PC logic stay in if_stage.

Verification
REQ-035 Reset release, gnt/rvalid each 1 cycle after request -> addresses BFC0_0000, _0004, _0008 in order; id_valid rises 2 cycles after first request.
REQ-036 stall=1 for 3 cycles while a response arrives -> id outputs frozen, word buffered, no imem_req; release -> buffered word presented next cycle, then fetch resumes at PC+4.
REQ-037 j at BFC0_0010 decoded, target BFC0_0100 -> delay slot BFC0_0014 delivered, next fetch BFC0_0100, no BFC0_0018.
REQ-038 branch_flag_i with imem_gnt held low 4 cycles -> imem_addr stable at delay-slot address, then BFC0_0100 requested.
REQ-039 Fetch PC FFFF_FFFC -> next address 0000_0000.
REQ-040 rst asserted in WAIT, stale imem_rvalid one cycle after release -> ignored, id_valid=0, fetch restarts at RESET_PC.
